// File: rtl/snn_pkg.sv
// Shared types for the spike rate monitor: parameter defaults,
// the per-window record layout and the window FSM states.
package snn_pkg;

    localparam int WIN_W = 16;
    localparam int CNT_W = 8;
    localparam int ISI_W = 12;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [ISI_W-1:0] isi;
        logic             ovf;
    } spike_rec_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/spike_rate_monitor_if.sv
// Record drain port of the spike rate monitor.
// master: drives rec_valid/rec_count/rec_isi/rec_ovf/fifo_level,
//         samples rec_ready. slave: the consumer side.
interface spike_rate_monitor_if #(
    parameter int CNT_W = snn_pkg::CNT_W,
    parameter int ISI_W = snn_pkg::ISI_W,
    parameter int LVL_W = 3
);

    logic             rec_valid;
    logic             rec_ready;
    logic [CNT_W-1:0] rec_count;
    logic [ISI_W-1:0] rec_isi;
    logic             rec_ovf;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output rec_valid,
        output rec_count,
        output rec_isi,
        output rec_ovf,
        output fifo_level,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_count,
        input  rec_isi,
        input  rec_ovf,
        input  fifo_level,
        output rec_ready
    );

endinterface

// File: rtl/spike_rec_fifo.sv
// Synchronous show-ahead record FIFO (DEPTH power of two, >= 2).
// Ports: clk, rst_n (sync, active-low), clear, push, pop, din,
//        dout (head), full, empty, level.
module spike_rec_fifo #(
    parameter int  DEPTH = 4,
    parameter type rec_t = snn_pkg::spike_rec_t,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  rec_t             din,
    output rec_t             dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// Turns the neuron spike flag into per-window records (count,
// min ISI, overflow) queued in a FIFO and drained over rec.
// Ports: clk, rst_n (sync, active-low), ena, spike_in, win_len,
//        clear, rec (master: valid/ready, count, isi, ovf, level).
// Macro SPIKE_ISI_EN builds the ISI logic; otherwise rec_isi = '1.
module spike_rate_monitor
    import snn_pkg::*;
#(
    parameter int WIN_W      = snn_pkg::WIN_W,
    parameter int CNT_W      = snn_pkg::CNT_W,
    parameter int ISI_W      = snn_pkg::ISI_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        spike_in,
    input  logic [WIN_W-1:0]            win_len,
    input  logic                        clear,
    spike_rate_monitor_if.master        rec
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ISI_W-1:0] ISI_NONE = '1;

`ifdef SPIKE_ISI_EN
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [ISI_W-1:0] isi;
        logic             ovf;
    } rec_t;
`else
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             ovf;
    } rec_t;
`endif

    state_t           state;
    state_t           state_nx;
    logic [WIN_W-1:0] win_left;
    logic [WIN_W-1:0] win_load;
    logic [WIN_W-1:0] cur_left;
    logic             win_end;
    logic             spike_q;
    logic             ev;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nx;
    logic             sat;
    logic             sat_nx;
    logic             drop;
    logic             pop;
    logic             push_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] level;
    rec_t             rec_in;
    rec_t             head;

    assign ev       = ena & spike_in & ~spike_q;
    assign win_load = (win_len == '0) ? '0 : win_len - 1'b1;

    // In IDLE the first enabled cycle is already window cycle 0,
    // so the freshly loaded length is used for the end test.
    always_comb begin
        state_nx = state;
        cur_left = win_left;
        unique case (state)
            IDLE: begin
                cur_left = win_load;
                if (ena) state_nx = RUN;
            end
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        win_end = ena & (cur_left == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) state <= IDLE;
        else                 state <= state_nx;
    end

    assign count_nx = (ev && count != CNT_MAX) ? count + 1'b1
                                               : count;
    assign sat_nx   = sat | (count_nx == CNT_MAX);
    assign pop      = ~fifo_empty & rec.rec_ready;
    assign push_ok  = ~fifo_full | pop;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            spike_q  <= 1'b0;
            win_left <= '0;
            count    <= '0;
            sat      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (ena) begin
                spike_q  <= spike_in;
                win_left <= win_end ? win_load : cur_left - 1'b1;
                count    <= win_end ? '0 : count_nx;
                sat      <= win_end ? 1'b0 : sat_nx;
            end
            // Sticky until a record carrying it is accepted.
            if (win_end) drop <= ~push_ok;
        end
    end

`ifdef SPIKE_ISI_EN
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] min_isi;
    logic [ISI_W-1:0] min_nx;
    logic             seen;

    always_comb begin
        min_nx = min_isi;
        if (ev && seen && isi_cnt < min_isi) min_nx = isi_cnt;
    end

    // isi_cnt holds enabled cycles elapsed since the last event.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            isi_cnt <= '0;
            min_isi <= ISI_NONE;
            seen    <= 1'b0;
        end else if (ena) begin
            if (ev) begin
                isi_cnt <= ISI_W'(1);
                seen    <= 1'b1;
            end else if (isi_cnt != ISI_NONE) begin
                isi_cnt <= isi_cnt + 1'b1;
            end
            min_isi <= win_end ? ISI_NONE : min_nx;
        end
    end
`endif

    always_comb begin
        rec_in       = '0;
        rec_in.count = count_nx;
        rec_in.ovf   = sat_nx | drop;
`ifdef SPIKE_ISI_EN
        rec_in.isi   = min_nx;
`endif
    end

    spike_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (win_end),
        .pop   (pop),
        .din   (rec_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign rec.rec_valid  = ~fifo_empty;
    assign rec.rec_count  = fifo_empty ? '0 : head.count;
    assign rec.rec_ovf    = fifo_empty ? 1'b0 : head.ovf;
    assign rec.fifo_level = level;
`ifdef SPIKE_ISI_EN
    assign rec.rec_isi    = fifo_empty ? '0 : head.isi;
`else
    assign rec.rec_isi    = ISI_NONE;
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Randomised and directed bench for spike_rate_monitor with a
// timestamp-based reference model of the window records.
module tb_spike_rate_monitor;

    localparam int WIN_W   = 16;
    localparam int CNT_W   = 8;
    localparam int ISI_W   = 12;
    localparam int DEPTH   = 4;
    localparam int LVL_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ONES    = (1 << ISI_W) - 1;
`ifdef SPIKE_ISI_EN
    localparam bit ISI_EN = 1'b1;
`else
    localparam bit ISI_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             spike_in;
    logic [WIN_W-1:0] win_len;
    logic             clear;

    int checks = 0;
    int errors = 0;

    spike_rate_monitor_if #(
        .CNT_W (CNT_W),
        .ISI_W (ISI_W),
        .LVL_W (LVL_W)
    ) rif ();

    spike_rate_monitor #(
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W),
        .ISI_W      (ISI_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spike_in (spike_in),
        .win_len  (win_len),
        .clear    (clear),
        .rec      (rif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: records built from enabled-cycle
    // timestamps and window positions.
    typedef struct {
        int count;
        int isi;
        bit ovf;
    } mrec_t;

    mrec_t q[$];
    bit    started = 1'b0;
    bit    m_prev;
    bit    m_inwin;
    bit    m_drop;
    int    m_t;
    int    m_last;
    int    m_n;
    int    m_min;
    int    m_wlen;
    int    m_wpos;

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            q.delete();
            m_prev  = 1'b0;
            m_inwin = 1'b0;
            m_drop  = 1'b0;
            m_t     = 0;
            m_last  = -1;
            m_n     = 0;
            m_min   = ONES;
            started = 1'b1;
        end else begin
            bit    ev;
            int    iv;
            mrec_t r;
            if (rif.rec_ready && q.size() > 0)
                void'(q.pop_front());
            if (ena) begin
                ev = spike_in && !m_prev;
                m_prev = spike_in;
                if (!m_inwin) begin
                    m_inwin = 1'b1;
                    m_wlen  = (win_len == 0) ? 1 : int'(win_len);
                    m_wpos  = 0;
                end
                if (ev) begin
                    m_n++;
                    if (m_last >= 0) begin
                        iv = m_t - m_last;
                        if (iv > ONES) iv = ONES;
                        if (iv < m_min) m_min = iv;
                    end
                    m_last = m_t;
                end
                if (m_wpos == m_wlen - 1) begin
                    r.count = (m_n > CNT_MAX) ? CNT_MAX : m_n;
                    r.isi   = m_min;
                    r.ovf   = (m_n >= CNT_MAX) || m_drop;
                    if (q.size() < DEPTH) begin
                        q.push_back(r);
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                    m_n    = 0;
                    m_min  = ONES;
                    m_wpos = 0;
                    m_wlen = (win_len == 0) ? 1 : int'(win_len);
                end else begin
                    m_wpos++;
                end
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int ec;
            int ei;
            int eo;
            int ev;
            ev = (q.size() > 0) ? 1 : 0;
            ec = 0;
            eo = 0;
            ei = ISI_EN ? 0 : ONES;
            if (ev != 0) begin
                ec = q[0].count;
                eo = int'(q[0].ovf);
                if (ISI_EN) ei = q[0].isi;
            end
            chk("m_valid", 32'(rif.rec_valid), 32'(ev));
            chk("m_level", 32'(rif.fifo_level), 32'(q.size()));
            chk("m_count", 32'(rif.rec_count), 32'(ec));
            chk("m_isi", 32'(rif.rec_isi), 32'(ei));
            chk("m_ovf", 32'(rif.rec_ovf), 32'(eo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pop_one();
        rif.rec_ready = 1'b1;
        tick();
        rif.rec_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst_n         = 1'b0;
        ena           = 1'b1;
        spike_in      = 1'b0;
        win_len       = 16'd10;
        clear         = 1'b0;
        rif.rec_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(rif.rec_valid), 0);
        chk("rst_level", 32'(rif.fifo_level), 0);
        chk("rst_count", 32'(rif.rec_count), 0);
        chk("rst_isi", 32'(rif.rec_isi), ISI_EN ? 0 : ONES);
        chk("rst_ovf", 32'(rif.rec_ovf), 0);

        // basic window, spikes at cycles 2, 5, 9
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            spike_in = (c == 2 || c == 5 || c == 9);
            tick();
        end
        spike_in = 1'b0;
        @(negedge clk);
        chk("basic_valid", 32'(rif.rec_valid), 1);
        chk("basic_count", 32'(rif.rec_count), 3);
        chk("basic_isi", 32'(rif.rec_isi), ISI_EN ? 3 : ONES);
        chk("basic_ovf", 32'(rif.rec_ovf), 0);
        pop_one();

        // held spike
        do_clear();
        win_len  = 16'd8;
        spike_in = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c == 20) spike_in = 1'b0;
            tick();
        end
        ena = 1'b0;
        @(negedge clk);
        chk("held_level", 32'(rif.fifo_level), 3);
        chk("held_c0", 32'(rif.rec_count), 1);
        chk("held_i0", 32'(rif.rec_isi), ONES);
        for (int k = 1; k < 3; k++) begin
            pop_one();
            @(negedge clk);
            chk("held_cn", 32'(rif.rec_count), 0);
            chk("held_in", 32'(rif.rec_isi), ONES);
        end
        pop_one();
        ena = 1'b1;

        // backpressure: 6 windows into a 4-deep FIFO
        do_clear();
        win_len = 16'd4;
        for (int c = 0; c < 24; c++) begin
            spike_in = 1'($urandom_range(0, 1));
            tick();
        end
        spike_in = 1'b0;
        ena      = 1'b0;
        @(negedge clk);
        chk("bp_level", 32'(rif.fifo_level), 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ovf0", 32'(rif.rec_ovf), 0);
            pop_one();
        end
        @(negedge clk);
        chk("bp_empty", 32'(rif.fifo_level), 0);
        ena = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        chk("bp_valid", 32'(rif.rec_valid), 1);
        chk("bp_ovf1", 32'(rif.rec_ovf), 1);
        pop_one();

        // saturation
        do_clear();
        win_len = 16'd1000;
        for (int c = 0; c < 1000; c++) begin
            spike_in = (c % 2 == 0);
            tick();
        end
        spike_in = 1'b0;
        @(negedge clk);
        chk("sat_count", 32'(rif.rec_count), CNT_MAX);
        chk("sat_ovf", 32'(rif.rec_ovf), 1);
        chk("sat_isi", 32'(rif.rec_isi), ISI_EN ? 2 : ONES);
        pop_one();

        // enable gap stretches the window
        do_clear();
        win_len = 16'd10;
        e = 0;
        for (int w = 0; w < 15; w++) begin
            ena      = !(w >= 5 && w < 10);
            spike_in = ena && (e == 1 || e == 4);
            tick();
            if (ena) e++;
            if (w == 9) begin
                @(negedge clk);
                chk("ena_early", 32'(rif.rec_valid), 0);
            end
        end
        ena      = 1'b1;
        spike_in = 1'b0;
        @(negedge clk);
        chk("ena_valid", 32'(rif.rec_valid), 1);
        chk("ena_count", 32'(rif.rec_count), 2);
        chk("ena_isi", 32'(rif.rec_isi), ISI_EN ? 3 : ONES);

        // clear with records queued
        do_clear();
        win_len = 16'd2;
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        chk("clr_before", 32'(rif.fifo_level), 2);
        do_clear();
        @(negedge clk);
        chk("clr_level", 32'(rif.fifo_level), 0);
        chk("clr_valid", 32'(rif.rec_valid), 0);
        win_len = 16'd4;
        for (int c = 0; c < 4; c++) begin
            spike_in = (c == 1);
            tick();
        end
        spike_in = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(rif.rec_count), 1);
        chk("clr_isi", 32'(rif.rec_isi), ONES);
        pop_one();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            ena           = ($urandom_range(0, 9) != 0);
            spike_in      = ($urandom_range(0, 2) == 0);
            rif.rec_ready = ($urandom_range(0, 3) != 0);
            if (i % 200 == 0)
                win_len = 16'($urandom_range(0, 12));
            clear = ($urandom_range(0, 499) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        clear         = 1'b0;
        rst_n         = 1'b1;
        rif.rec_ready = 1'b0;
        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
